simmem_delay_tracker: RTL



---
 rtl/simmem_delay_tracker.sv | 90 +++++++++
 1 files changed

// File: rtl/simmem_delay_tracker.sv
// simmem_delay_tracker: holds (id, delay) pairs in slots and releases each id once its delay has elapsed
module simmem_delay_tracker #(
  parameter int IdWidth    = 4,
  parameter int DelayWidth = 6,
  parameter int NumSlots   = 8,
  localparam int CntW      = $clog2(NumSlots + 1),
  localparam int IdxW      = $clog2(NumSlots)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [IdWidth-1:0]    local_identifier_i,
  input  logic [DelayWidth-1:0] delay_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [IdWidth-1:0]    local_identifier_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CntW-1:0]       slots_used_o
);
  logic [NumSlots-1:0]   occ;
  logic [IdWidth-1:0]    ids [NumSlots];
  logic [DelayWidth-1:0] cnt [NumSlots];
  logic                  locked;
  logic [IdxW-1:0]       lock_idx;
  logic [IdxW-1:0]       exp_idx;
  logic [IdxW-1:0]       free_idx;
  logic [IdxW-1:0]       sel;
  logic                  any_exp;
  logic                  accept;
  logic                  rel;
  // Priority pick of the lowest expired slot and the lowest free slot; descending scan lets low indices win
  always_comb begin
    exp_idx  = '0;
    free_idx = '0;
    any_exp  = 1'b0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (occ[i] && cnt[i] == '0) begin
        exp_idx = IdxW'(i);
        any_exp = 1'b1;
      end
      if (!occ[i]) free_idx = IdxW'(i);
    end
  end
  // A stalled release pins the selection so the presented id cannot change under backpressure
  assign sel                = locked ? lock_idx : exp_idx;
  assign out_valid_o        = locked | any_exp;
  assign local_identifier_o = out_valid_o ? ids[sel] : '0;
  assign in_ready_o         = ~&occ;
  assign accept             = in_valid_i && in_ready_o;
  assign rel                = out_valid_o && out_ready_i;
  // Slot storage: allocate on accept, free on release, count occupied slots down to zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        ids[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (accept && free_idx == IdxW'(i)) begin
          occ[i] <= 1'b1;
          ids[i] <= local_identifier_i;
          cnt[i] <= delay_i;
        end else begin
          if (rel && sel == IdxW'(i)) occ[i] <= 1'b0;
          if (occ[i] && cnt[i] != '0) cnt[i] <= cnt[i] - DelayWidth'(1);
        end
      end
    end
  end
  // Output lock: set while the downstream stalls a valid release, cleared by the release itself
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (rel) begin
      locked <= 1'b0;
    end else if (out_valid_o) begin
      locked   <= 1'b1;
      lock_idx <= sel;
    end
  end
  // Occupancy count tracks accepts minus releases
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) slots_used_o <= '0;
    else if (accept && !rel) slots_used_o <= slots_used_o + CntW'(1);
    else if (rel && !accept) slots_used_o <= slots_used_o - CntW'(1);
  end
endmodule
